// File: rtl/hdb3_pkg.sv
// Shared constants and types for the HDB3 decoder slice.
package hdb3_pkg;

    // Ternary line symbols as carried on the 2-bit code bus.
    localparam logic [1:0] SYM_ZERO = 2'b00;
    localparam logic [1:0] SYM_POS  = 2'b01;
    localparam logic [1:0] SYM_NEG  = 2'b10;
    localparam logic [1:0] SYM_ILL  = 2'b11;

    typedef enum logic {
        POL_NEG = 1'b0,
        POL_POS = 1'b1
    } pol_e;

    // A substitution group spans four symbols (000V / B00V).
    localparam int unsigned DELAY_LEN    = 4;
    // Longest legal run of zeros on an HDB3 line.
    localparam int unsigned MAX_ZERO_RUN = 3;

    function automatic logic is_mark_sym(input logic [1:0] code);
        return (code == SYM_POS) || (code == SYM_NEG);
    endfunction

endpackage

// File: rtl/hdb3_decoder_if.sv
// Symbol-in / NRZ-out bus of the HDB3 decoder.
// o_err_cnt is present only when HDB3_ERR_CNT_EN is defined.
interface hdb3_decoder_if #(
    parameter int unsigned ERR_CNT_W = 16
) ();

    logic       i_code_valid;
    logic [1:0] i_hdb3_code;
    logic       o_data;
    logic       o_data_valid;
    logic       o_v_det;
    logic       o_code_err;
`ifdef HDB3_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] o_err_cnt;
`endif

    // A zero-width counter is meaningless.
    if (ERR_CNT_W == 0) begin : g_bad_width
        $error("hdb3_decoder_if: ERR_CNT_W must be non-zero");
    end

    // Symbol source side.
    modport master (
        output i_code_valid,
        output i_hdb3_code,
        input  o_data,
        input  o_data_valid,
        input  o_v_det,
        input  o_code_err
`ifdef HDB3_ERR_CNT_EN
        , input o_err_cnt
`endif
    );

    // Decoder side.
    modport slave (
        input  i_code_valid,
        input  i_hdb3_code,
        output o_data,
        output o_data_valid,
        output o_v_det,
        output o_code_err
`ifdef HDB3_ERR_CNT_EN
        , output o_err_cnt
`endif
    );

endinterface

// File: rtl/hdb3_violation_chk.sv
// Per-symbol HDB3 classifier: tracks mark polarity, V polarity and zero runs,
// and flags each symbol as mark / V / code error. Outputs are combinational
// on the current symbol; state advances only on valid symbols.
module hdb3_violation_chk
    import hdb3_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_code_valid,
    input  logic [1:0] i_code,
    output logic       o_is_mark,
    output logic       o_is_v,
    output logic       o_code_err
);

    localparam int unsigned ZW = $clog2(MAX_ZERO_RUN + 1);

    pol_e          last_pol_q;
    pol_e          last_v_pol_q;
    logic          v_seen_q;
    logic [ZW-1:0] zero_cnt_q;

    pol_e sym_pol;
    logic ill_err;
    logic zero_err;
    logic v_pol_err;

    // Classify the symbol currently on the bus.
    always_comb begin
        sym_pol    = (i_code == SYM_POS) ? POL_POS : POL_NEG;
        o_is_mark  = is_mark_sym(i_code);
        o_is_v     = o_is_mark && (sym_pol == last_pol_q);
        ill_err    = (i_code == SYM_ILL);
        zero_err   = (i_code == SYM_ZERO) && (zero_cnt_q == ZW'(MAX_ZERO_RUN));
        // Consecutive V pulses must alternate; the first V has no reference.
        v_pol_err  = o_is_v && v_seen_q && (sym_pol == last_v_pol_q);
        o_code_err = ill_err || zero_err || v_pol_err;
    end

    // Polarity and zero-run history, advanced per valid symbol.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            last_pol_q   <= POL_NEG;
            last_v_pol_q <= POL_NEG;
            v_seen_q     <= 1'b0;
            zero_cnt_q   <= '0;
        end else if (i_code_valid) begin
            if (o_is_mark) begin
                last_pol_q <= sym_pol;
            end
            if (o_is_v) begin
                v_seen_q     <= 1'b1;
                last_v_pol_q <= sym_pol;
            end
            // Saturate so every further zero re-flags.
            if (i_code == SYM_ZERO) begin
                if (zero_cnt_q != ZW'(MAX_ZERO_RUN)) begin
                    zero_cnt_q <= zero_cnt_q + 1'b1;
                end
            end else begin
                zero_cnt_q <= '0;
            end
        end
    end

endmodule

// File: rtl/hdb3_decoder.sv
// HDB3 line decoder: ternary symbols in, NRZ bits out with 4-symbol latency.
// A V pulse zeroes itself and the three preceding symbols in the delay line,
// which removes both 000V and B00V substitutions.
// Define HDB3_ERR_CNT_EN to add the saturating o_err_cnt code-error counter.
module hdb3_decoder
    import hdb3_pkg::*;
#(
    parameter int unsigned ERR_CNT_W = 16
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    hdb3_decoder_if.slave bus
);

    localparam int unsigned FW = $clog2(DELAY_LEN + 1);

    logic [DELAY_LEN-1:0] sr_q;
    logic [FW-1:0]        fill_q;
    logic                 data_q;
    logic                 data_valid_q;
    logic                 v_det_q;
    logic                 code_err_q;

    logic is_mark;
    logic is_v;
    logic code_err;

    if (ERR_CNT_W == 0) begin : g_bad_width
        $error("hdb3_decoder: ERR_CNT_W must be non-zero");
    end

    hdb3_violation_chk u_chk (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_code_valid (bus.i_code_valid),
        .i_code       (bus.i_hdb3_code),
        .o_is_mark    (is_mark),
        .o_is_v       (is_v),
        .o_code_err   (code_err)
    );

    // Delay line, fill tracking and registered output pulses.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            sr_q         <= '0;
            fill_q       <= '0;
            data_q       <= 1'b0;
            data_valid_q <= 1'b0;
            v_det_q      <= 1'b0;
            code_err_q   <= 1'b0;
        end else begin
            data_valid_q <= 1'b0;
            v_det_q      <= 1'b0;
            code_err_q   <= 1'b0;
            if (bus.i_code_valid) begin
                // Illegal symbols are not marks, so they enter as 0.
                sr_q <= is_v ? '0 : {sr_q[DELAY_LEN-2:0], is_mark};
                if (fill_q != FW'(DELAY_LEN)) begin
                    fill_q <= fill_q + 1'b1;
                end else begin
                    // Oldest symbol leaves before any V clear takes effect.
                    data_q       <= sr_q[DELAY_LEN-1];
                    data_valid_q <= 1'b1;
                end
                v_det_q    <= is_v;
                code_err_q <= code_err;
            end
        end
    end

    assign bus.o_data       = data_q;
    assign bus.o_data_valid = data_valid_q;
    assign bus.o_v_det      = v_det_q;
    assign bus.o_code_err   = code_err_q;

`ifdef HDB3_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] err_cnt_q;

    // Counts alongside the o_code_err pulse; saturates, cleared only by reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            err_cnt_q <= '0;
        end else if (bus.i_code_valid && code_err && (err_cnt_q != '1)) begin
            err_cnt_q <= err_cnt_q + 1'b1;
        end
    end

    assign bus.o_err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_hdb3_decoder.sv
// Bench for hdb3_decoder: hand-derived per-symbol expectations, decoded bits
// queued at drive time and popped when an output bit is due.
module tb_hdb3_decoder;
    import hdb3_pkg::*;

    localparam int unsigned ERR_CNT_W = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    hdb3_decoder_if #(.ERR_CNT_W(ERR_CNT_W)) bus ();

    hdb3_decoder #(.ERR_CNT_W(ERR_CNT_W)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    int          acc   = 0;
    logic        hold  = 1'b0;
    int unsigned ecnt  = 0;
    logic        exp_q[$];
    string       cur_test = "init";

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s.%s: got %0h expected %0h", cur_test, tag, got, exp);
        end
    endtask

    // One clock: drive a symbol (or a gap), then check the outputs it causes.
    task automatic step(input logic vld, input logic [1:0] code,
                        input logic ev, input logic ee, input logic ed);
        logic exp_dv;
        @(negedge clk);
        bus.i_code_valid = vld;
        bus.i_hdb3_code  = code;
        exp_dv = 1'b0;
        if (vld) begin
            exp_q.push_back(ed);
            if (acc >= int'(DELAY_LEN)) begin
                exp_dv = 1'b1;
                hold   = exp_q.pop_front();
            end else begin
                acc++;
            end
            if (ee) ecnt++;
        end
        @(posedge clk);
        #1;
        check_eq("data_valid", 32'(bus.o_data_valid), 32'(exp_dv));
        check_eq("data", 32'(bus.o_data), 32'(hold));
        check_eq("v_det", 32'(bus.o_v_det), 32'(vld & ev));
        check_eq("code_err", 32'(bus.o_code_err), 32'(vld & ee));
    endtask

    task automatic sym(input logic [1:0] code, input logic ev, input logic ee, input logic ed);
        step(1'b1, code, ev, ee, ed);
    endtask

    task automatic gap();
        step(1'b0, 2'($urandom_range(0, 3)), 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_cnt();
`ifdef HDB3_ERR_CNT_EN
        check_eq("err_cnt", 32'(bus.o_err_cnt), ecnt);
`endif
    endtask

    // Four non-V marks alternating from the given polarity, to flush the line.
    task automatic pad(input logic start_pos);
        for (int i = 0; i < 4; i++) begin
            sym(((i % 2 == 0) == start_pos) ? SYM_POS : SYM_NEG, 1'b0, 1'b0, 1'b1);
        end
    endtask

    // One reset cycle; the symbol driven during it must be ignored.
    task automatic do_reset(input logic vld, input logic [1:0] code);
        @(negedge clk);
        rst_n = 1'b0;
        bus.i_code_valid = vld;
        bus.i_hdb3_code  = code;
        exp_q.delete();
        acc  = 0;
        hold = 1'b0;
        ecnt = 0;
        @(posedge clk);
        #1;
        check_eq("rst_data_valid", 32'(bus.o_data_valid), 32'd0);
        check_eq("rst_data", 32'(bus.o_data), 32'd0);
        check_eq("rst_v_det", 32'(bus.o_v_det), 32'd0);
        check_eq("rst_code_err", 32'(bus.o_code_err), 32'd0);
        check_cnt();
        @(negedge clk);
        rst_n = 1'b1;
        bus.i_code_valid = 1'b0;
        bus.i_hdb3_code  = SYM_ZERO;
    endtask

    logic [1:0] t6_code[10];
    logic       t6_d[10];

    initial begin
        bus.i_code_valid = 1'b0;
        bus.i_hdb3_code  = SYM_ZERO;

        // 1: 000V
        cur_test = "t1_000v";
        do_reset(1'b0, SYM_ZERO);
        sym(SYM_POS,  1'b0, 1'b0, 1'b1);
        sym(SYM_ZERO, 1'b0, 1'b0, 1'b0);
        sym(SYM_ZERO, 1'b0, 1'b0, 1'b0);
        sym(SYM_ZERO, 1'b0, 1'b0, 1'b0);
        sym(SYM_POS,  1'b1, 1'b0, 1'b0);
        sym(SYM_NEG,  1'b0, 1'b0, 1'b1);
        pad(1'b1);
        check_cnt();

        // 2: B00V
        cur_test = "t2_b00v";
        do_reset(1'b0, SYM_ZERO);
        sym(SYM_POS,  1'b0, 1'b0, 1'b1);
        sym(SYM_NEG,  1'b0, 1'b0, 1'b1);
        sym(SYM_POS,  1'b0, 1'b0, 1'b0);
        sym(SYM_ZERO, 1'b0, 1'b0, 1'b0);
        sym(SYM_ZERO, 1'b0, 1'b0, 1'b0);
        sym(SYM_POS,  1'b1, 1'b0, 1'b0);
        sym(SYM_NEG,  1'b0, 1'b0, 1'b1);
        pad(1'b1);
        check_cnt();

        // 3: zero run of five
        cur_test = "t3_zeros";
        do_reset(1'b0, SYM_ZERO);
        sym(SYM_POS,  1'b0, 1'b0, 1'b1);
        sym(SYM_ZERO, 1'b0, 1'b0, 1'b0);
        sym(SYM_ZERO, 1'b0, 1'b0, 1'b0);
        sym(SYM_ZERO, 1'b0, 1'b0, 1'b0);
        sym(SYM_ZERO, 1'b0, 1'b1, 1'b0);
        sym(SYM_ZERO, 1'b0, 1'b1, 1'b0);
        pad(1'b0);
        check_cnt();

        // 4: illegal symbol, polarity untouched
        cur_test = "t4_illegal";
        do_reset(1'b0, SYM_ZERO);
        sym(SYM_POS, 1'b0, 1'b0, 1'b1);
        sym(SYM_ILL, 1'b0, 1'b1, 1'b0);
        sym(SYM_NEG, 1'b0, 1'b0, 1'b1);
        pad(1'b1);
        check_cnt();

        // 5: two positive V pulses in a row
        cur_test = "t5_vpair";
        do_reset(1'b0, SYM_ZERO);
        sym(SYM_POS,  1'b0, 1'b0, 1'b1);
        sym(SYM_ZERO, 1'b0, 1'b0, 1'b0);
        sym(SYM_ZERO, 1'b0, 1'b0, 1'b0);
        sym(SYM_ZERO, 1'b0, 1'b0, 1'b0);
        sym(SYM_POS,  1'b1, 1'b0, 1'b0);
        sym(SYM_ZERO, 1'b0, 1'b0, 1'b0);
        sym(SYM_ZERO, 1'b0, 1'b0, 1'b0);
        sym(SYM_ZERO, 1'b0, 1'b0, 1'b0);
        sym(SYM_POS,  1'b1, 1'b1, 1'b0);
        pad(1'b0);
        check_cnt();

        // 6: random gaps, then reset mid-stream with a valid mark on the bus
        cur_test = "t6_gaps";
        do_reset(1'b0, SYM_ZERO);
        t6_code = '{SYM_POS, SYM_NEG, SYM_POS, SYM_NEG, SYM_POS,
                    SYM_ZERO, SYM_NEG, SYM_POS, SYM_ZERO, SYM_NEG};
        t6_d    = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 10; i++) begin
            repeat ($urandom_range(0, 3)) gap();
            sym(t6_code[i], 1'b0, 1'b0, t6_d[i]);
        end
        cur_test = "t6_midrst";
        do_reset(1'b1, SYM_POS);
        sym(SYM_POS,  1'b0, 1'b0, 1'b1);
        gap();
        sym(SYM_NEG,  1'b0, 1'b0, 1'b1);
        sym(SYM_ZERO, 1'b0, 1'b0, 1'b0);
        gap();
        sym(SYM_POS,  1'b0, 1'b0, 1'b1);
        sym(SYM_NEG,  1'b0, 1'b0, 1'b1);
        sym(SYM_POS,  1'b0, 1'b0, 1'b1);
        pad(1'b0);
        check_cnt();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
